// File: rtl/midi_writer.sv
// MIDI channel-message transmitter: frames status/data bytes (with optional running
// status) and shifts them out as 8N1 UART on tx_out.
module midi_writer #(
    parameter int CLK_HZ         = 100_000_000,
    parameter int BAUD           = 31_250,
    parameter bit RUNNING_STATUS = 1'b1
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [3:0] status_in,
    input  logic [3:0] channel_in,
    input  logic [7:0] data_byte1_in,
    input  logic [7:0] data_byte2_in,
    input  logic       valid_in,
    output logic       ready_out,
    output logic       tx_out,
    output logic       done_out,
    output logic       error_out
);

    localparam int BAUD_DIV = CLK_HZ / BAUD;
    localparam int CW       = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [1:0]      byte_q, byte_d;
    logic [1:0]      last_idx_q, last_idx_d;
    logic [2:0][7:0] buf_q, buf_d;
    logic [7:0]      last_status_q, last_status_d;
    logic            last_valid_q, last_valid_d;
    logic            tx_q, tx_d;
    logic            done_q, done_d;
    logic            error_q, error_d;

    logic [7:0]      status_byte;
    logic [7:0]      d1_masked;
    logic [7:0]      d2_masked;
    logic            skip_status;
    logic            two_data;
    logic            baud_wrap;

    always_comb begin
        state_d       = state_q;
        baud_d        = baud_q;
        bit_d         = bit_q;
        byte_d        = byte_q;
        last_idx_d    = last_idx_q;
        buf_d         = buf_q;
        last_status_d = last_status_q;
        last_valid_d  = last_valid_q;
        done_d        = 1'b0;
        error_d       = 1'b0;
        tx_d          = 1'b1;

        status_byte = {status_in, channel_in};
        d1_masked   = data_byte1_in & 8'h7F;
        d2_masked   = data_byte2_in & 8'h7F;
        skip_status = RUNNING_STATUS && last_valid_q && (last_status_q == status_byte);
        two_data    = (status_in != 4'hC) && (status_in != 4'hD);
        baud_wrap   = (baud_q == CW'(BAUD_DIV - 1));

        case (state_q)
            IDLE: begin
                if (valid_in) begin
                    if (status_in < 4'h8 || status_in == 4'hF) begin
                        error_d = 1'b1;
                    end else begin
                        // Message bytes are packed from slot 0 so the shifter never needs to know about skipping.
                        if (skip_status) begin
                            buf_d[0]   = d1_masked;
                            buf_d[1]   = d2_masked;
                            buf_d[2]   = 8'h00;
                            last_idx_d = two_data ? 2'd1 : 2'd0;
                        end else begin
                            buf_d[0]   = status_byte;
                            buf_d[1]   = d1_masked;
                            buf_d[2]   = d2_masked;
                            last_idx_d = two_data ? 2'd2 : 2'd1;
                        end
                        last_status_d = status_byte;
                        last_valid_d  = 1'b1;
                        state_d       = START;
                        baud_d        = '0;
                        bit_d         = '0;
                        byte_d        = '0;
                    end
                end
            end
            START: begin
                baud_d = baud_q + CW'(1);
                if (baud_wrap) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                baud_d = baud_q + CW'(1);
                if (baud_wrap) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            STOP: begin
                baud_d = baud_q + CW'(1);
                if (baud_wrap) begin
                    baud_d = '0;
                    if (byte_q == last_idx_q) begin
                        state_d = IDLE;
                        byte_d  = '0;
                        done_d  = 1'b1;
                    end else begin
                        byte_d  = byte_q + 2'd1;
                        state_d = START;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // The line level is registered from the next state so tx_out never glitches.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = buf_d[byte_d][bit_d];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q       <= IDLE;
            baud_q        <= '0;
            bit_q         <= '0;
            byte_q        <= '0;
            last_idx_q    <= '0;
            buf_q         <= '0;
            last_status_q <= '0;
            last_valid_q  <= 1'b0;
            tx_q          <= 1'b1;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            baud_q        <= baud_d;
            bit_q         <= bit_d;
            byte_q        <= byte_d;
            last_idx_q    <= last_idx_d;
            buf_q         <= buf_d;
            last_status_q <= last_status_d;
            last_valid_q  <= last_valid_d;
            tx_q          <= tx_d;
            done_q        <= done_d;
            error_q       <= error_d;
        end
    end

    assign ready_out = (state_q == IDLE);
    assign tx_out    = tx_q;
    assign done_out  = done_q;
    assign error_out = error_q;

endmodule
